// File: rtl/sar_sequencer.sv
// Successive-approximation ADC sequencer: sample/hold phase, then MSB-first bit trials.
// Every output is a register; the result goes out over a valid/ready handshake with a sticky overrun flag.
module sar_sequencer #(
    parameter int N_BITS        = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int TRIAL_CYCLES  = 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              cmp_in,
    input  logic              out_ready,
    input  logic              clr_ovr,
    output logic              sample_en,
    output logic [N_BITS-1:0] dac_code,
    output logic              busy,
    output logic [N_BITS-1:0] result,
    output logic              out_valid,
    output logic              overrun
);
    localparam int CMAX = (SAMPLE_CYCLES > TRIAL_CYCLES) ? SAMPLE_CYCLES : TRIAL_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [CW-1:0]     SAMP_LAST  = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0]     TRIAL_LAST = CW'(TRIAL_CYCLES - 1);
    localparam logic [BW-1:0]     MSB_IDX    = BW'(N_BITS - 1);
    localparam logic [N_BITS-1:0] MSB_CODE   = N_BITS'(1) << (N_BITS - 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              sample_en_q, sample_en_d;
    logic              busy_q, busy_d;
    logic [N_BITS-1:0] dac_q, dac_d;
    logic [N_BITS-1:0] result_q, result_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    logic              trial_end, conv_done;
    logic [N_BITS-1:0] trial_mask, kept_code;

    assign trial_end  = (state_q == CONVERT) && (cnt_q == TRIAL_LAST);
    assign conv_done  = trial_end && (bit_q == '0);
    assign trial_mask = N_BITS'(1) << bit_q;
    assign kept_code  = cmp_in ? dac_q : (dac_q & ~trial_mask);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sample_en_q <= 1'b0;
            busy_q      <= 1'b0;
            dac_q       <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sample_en_q <= sample_en_d;
            busy_q      <= busy_d;
            dac_q       <= dac_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end
            end
            SAMPLE: begin
                if (cnt_q == SAMP_LAST) begin
                    state_d = CONVERT;
                    cnt_d   = '0;
                    bit_d   = MSB_IDX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CONVERT: begin
                if (trial_end) begin
                    cnt_d = '0;
                    if (bit_q == '0) state_d = cont ? SAMPLE : IDLE;
                    else             bit_d   = bit_q - BW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sample_en_d = (state_d == SAMPLE);
        busy_d      = (state_d != IDLE);
        dac_d       = dac_q;
        result_d    = result_q;
        valid_d     = valid_q & ~out_ready;
        if (state_q == SAMPLE && state_d == CONVERT)
            dac_d = MSB_CODE;
        else if (trial_end)
            dac_d = conv_done ? '0 : (kept_code | (trial_mask >> 1));
        if (conv_done) begin
            result_d = kept_code;
            valid_d  = 1'b1;
        end
        // A fresh result landing on an unconsumed one is an overrun; setting beats clearing.
        overrun_d = (conv_done & valid_q & ~out_ready) | (overrun_q & ~clr_ovr);
    end

    assign sample_en = sample_en_q;
    assign busy      = busy_q;
    assign dac_code  = dac_q;
    assign result    = result_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;
endmodule

// File: doc/sar_sequencer.md
Name: sar_sequencer

Overview:
- Successive-approximation controller for the tiny-SAR ADC, running in the divided sample-clock domain.
- Sequences one conversion: sample/hold phase, then MSB-first bit trials. Drives the capacitive DAC code, reads the comparator, and returns a result over a valid/ready handshake.
- Supports single-shot (start pulse) and continuous modes, with an overrun flag.

Parameters:
- N_BITS, 8: resolution, i.e. width of dac_code and result.
- SAMPLE_CYCLES, 2: cycles sample_en is held high per conversion; legal range is 1 or more.
- TRIAL_CYCLES, 1: cycles per bit trial; comparator sampled on the last cycle of each trial; legal range is 1 or more.

Ports:
- clk_in  in  1  conversion clock (divided sample clock).
- rst  in  1  asynchronous reset, active-high.
- start  in  1  conversion request; sampled only in IDLE.
- cont  in  1  continuous mode; sampled on the final trial cycle.
- cmp_in  in  1  comparator output; 1 means Vin >= Vdac(dac_code).
- out_ready  in  1  result consumer ready.
- clr_ovr  in  1  clears overrun.
- sample_en  out  1  S/H switch enable.
- dac_code  out  N_BITS  DAC trial code.
- busy  out  1  high in any state except IDLE.
- result  out  N_BITS  converted code; stable while out_valid=1.
- out_valid  out  1  result available.
- overrun  out  1  sticky; an unconsumed result was overwritten.

Behaviour:
- Reset (async, immediate): state=IDLE. sample_en, busy, out_valid, overrun = 0. dac_code and result = 0. Internal bit index and trial counter = 0.
- States: IDLE, SAMPLE, CONVERT.
- IDLE, start=1 at posedge -> SAMPLE. start in other states is ignored.
- SAMPLE:
  - sample_en=1 and dac_code=0 for exactly SAMPLE_CYCLES cycles.
  - Then -> CONVERT with bit index=N_BITS-1, dac_code = 1<<(N_BITS-1).
- CONVERT:
  - Trial i lasts TRIAL_CYCLES cycles, and dac_code is constant during the trial.
  - On the last cycle of trial i, cmp_in is registered. Bit i is kept if cmp_in=1 and cleared if cmp_in=0.
  - If i>0, bit i-1 is set for the next trial; dac_code updates on the same edge.
  - After trial 0, on the same edge: result <= final code and out_valid <= 1. Next state is SAMPLE if cont=1, else IDLE. dac_code <= 0.
- Latency: the start edge is cycle 0. out_valid rises at cycle 1 + SAMPLE_CYCLES + N_BITS*TRIAL_CYCLES (11 for the defaults).
- Handshake:
  - out_valid falls on the edge where out_valid && out_ready.
  - result holds until consumed or overwritten.
- Completion while out_valid=1:
  - If out_ready=1 on that same edge, result is replaced with out_valid remaining 1, and there is no overrun.
  - If out_ready=0, result is replaced and overrun <= 1.
- overrun clears only via clr_ovr=1 or rst. If a set and clr_ovr coincide on the same edge, the set wins.
- cont=0 while in SAMPLE or CONVERT: the current conversion finishes, then the block returns to IDLE.
- busy = (state != IDLE) and is registered with the state.
- A reset mid-conversion aborts immediately. Outputs go to reset values, and the partial code is discarded.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Defaults, comparator model cmp_in=(vin >= dac_code), vin=0xA5, single start pulse:
  - sample_en high for cycles 1-2.
  - dac_code sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - out_valid at cycle 11 with result=0xA5.
  - busy drops at cycle 11.
- Boundary codes: vin=0x00 -> result=0x00; vin=0xFF -> result=0xFF. The model accepts all trials for 0xFF and rejects all for 0x00.
- TRIAL_CYCLES=3, vin=0x3C:
  - Each dac_code is held for 3 cycles; cmp_in is toggled randomly except on the last cycle of each trial.
  - Required: result=0x3C, out_valid at cycle 27.
- cont=1, out_ready=0, vin=0x12 then 0x34:
  - Second completion gives result=0x34 and overrun=1.
  - clr_ovr pulse -> overrun=0.
  - Repeat with out_ready=1 at the second completion -> overrun stays 0 and out_valid stays 1.
- Handshake: out_ready held 0 for 5 cycles after completion -> result stable, out_valid=1. out_ready=1 -> out_valid=0 next edge.
- Reset asserted asynchronously mid-CONVERT (cycle 6):
  - All outputs are 0 before the next edge.
  - After release, start is honoured and the conversion completes normally.
  - start asserted during busy is ignored: only one result is produced.
